// File: rtl/combo_lock_pkg.sv
// Shared definitions for the combination-lock controller: state encoding, default sizes, combo packing.
// Latency: none (declarations and a pure function only).
// Backpressure: not applicable.
package combo_lock_pkg;

    localparam int CODE_LEN_DEF = 4;
    localparam int DIGIT_W_DEF  = 4;

    // 3-bit state encoding shared by the controller and anything observing it
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ENTER   = 3'd1;
    localparam logic [2:0] ST_CHECK   = 3'd2;
    localparam logic [2:0] ST_OPEN    = 3'd3;
    localparam logic [2:0] ST_FAIL    = 3'd4;
    localparam logic [2:0] ST_LOCKOUT = 3'd5;
    localparam logic [2:0] ST_PROGRAM = 3'd6;

    // Packs digits into a combo word; digits[0] is entered first and lands in the MSBs
    function automatic logic [CODE_LEN_DEF*DIGIT_W_DEF-1:0] pack_combo(
        input logic [CODE_LEN_DEF-1:0][DIGIT_W_DEF-1:0] digits
    );
        logic [CODE_LEN_DEF*DIGIT_W_DEF-1:0] word;
        word = '0;
        for (int i = 0; i < CODE_LEN_DEF; i++) begin
            word = (word << DIGIT_W_DEF) | (CODE_LEN_DEF*DIGIT_W_DEF)'(digits[i]);
        end
        return word;
    endfunction

endpackage

// File: rtl/combo_lock_timer.sv
// Loadable down-counter shared by the OPEN and LOCKOUT dwell periods.
// Latency: start loads on the next edge; done is combinational while enabled and the count is zero.
// Backpressure: none; the counter parks at zero and never wraps.
module combo_lock_timer #(
    parameter int W = 8
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         start,
    input  logic [W-1:0] load_value,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count;

    // Load on start, otherwise count down while enabled and hold at zero
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            count <= '0;
        end else if (start) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = en && (count == '0);

endmodule

// File: rtl/combo_lock_fsm.sv
// Combination-lock controller: collects digit pulses, checks the code, drives unlock/fail/lockout.
// Latency: last digit pulse -> unlocked or bad_pulse after 2 cycles (one CHECK cycle in between).
// Backpressure: none; digits arriving in CHECK/FAIL/OPEN/LOCKOUT are dropped. COMBO_LOCK_PROG_EN adds reprogramming.
module combo_lock_fsm
    import combo_lock_pkg::*;
#(
    parameter int                          CODE_LEN       = CODE_LEN_DEF,
    parameter int                          DIGIT_W        = DIGIT_W_DEF,
    parameter logic [CODE_LEN*DIGIT_W-1:0] COMBO          = 16'h1234,
    parameter int                          MAX_TRIES      = 3,
    parameter int                          OPEN_CYCLES    = 50_000_000,
    parameter int                          LOCKOUT_CYCLES = 250_000_000
) (
    input  logic                           Clock,
    input  logic                           Resetn,
    input  logic                           digit_valid,
    input  logic [DIGIT_W-1:0]             digit,
    input  logic                           clear,
`ifdef COMBO_LOCK_PROG_EN
    input  logic                           prog,
`endif
    output logic                           unlocked,
    output logic                           bad_pulse,
    output logic                           alarm,
    output logic [$clog2(CODE_LEN+1)-1:0]  digits_entered,
    output logic [$clog2(MAX_TRIES+1)-1:0] fail_count
);

    localparam int EW   = CODE_LEN * DIGIT_W;
    localparam int DW   = $clog2(CODE_LEN + 1);
    localparam int FW   = $clog2(MAX_TRIES + 1);
    localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [DW-1:0] LAST_IDX  = DW'(CODE_LEN - 1);
    localparam logic [FW-1:0] TRIES_MAX = FW'(MAX_TRIES);
    localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCKOUT_CYCLES - 1);

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [EW-1:0] entry;
    logic [EW-1:0] combo;
    logic [FW-1:0] fail_inc;
    logic          match;
    logic          last_digit;
    logic          tmr_start;
    logic [TW-1:0] tmr_load;
    logic          tmr_done;

`ifdef COMBO_LOCK_PROG_EN
    logic [EW-1:0] shadow;
    logic [EW-1:0] shadow_nxt;
    assign shadow_nxt = (shadow << DIGIT_W) | EW'(digit);
`else
    assign combo = COMBO;
`endif

    assign match      = (entry == combo);
    assign last_digit = digit_valid && (digits_entered == LAST_IDX);
    assign fail_inc   = fail_count + 1'b1;

    combo_lock_timer #(
        .W (TW)
    ) u_timer (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .start      (tmr_start),
        .load_value (tmr_load),
        .en         ((state == ST_OPEN) || (state == ST_LOCKOUT)),
        .done       (tmr_done)
    );

    // Next-state logic; the timer is (re)loaded on the edge that enters OPEN or LOCKOUT
    always_comb begin
        state_nxt = state;
        tmr_start = 1'b0;
        tmr_load  = '0;
        case (state)
            ST_IDLE, ST_ENTER: begin
                if (clear) begin
                    state_nxt = ST_IDLE;
                end else if (digit_valid) begin
                    state_nxt = last_digit ? ST_CHECK : ST_ENTER;
                end
            end
            ST_CHECK: begin
                if (match) begin
                    state_nxt = ST_OPEN;
                    tmr_start = 1'b1;
                    tmr_load  = OPEN_LOAD;
                end else begin
                    state_nxt = ST_FAIL;
                end
            end
            ST_FAIL: begin
                if (fail_inc == TRIES_MAX) begin
                    state_nxt = ST_LOCKOUT;
                    tmr_start = 1'b1;
                    tmr_load  = LOCK_LOAD;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_OPEN: begin
                if (clear) begin
                    state_nxt = ST_IDLE;
`ifdef COMBO_LOCK_PROG_EN
                end else if (prog) begin
                    state_nxt = ST_PROGRAM;
`endif
                end else if (tmr_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_done) begin
                    state_nxt = ST_IDLE;
                end
            end
`ifdef COMBO_LOCK_PROG_EN
            ST_PROGRAM: begin
                if (clear || last_digit) begin
                    state_nxt = ST_IDLE;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, entry shift register, digit and failure counters (and the programmable combo)
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state          <= ST_IDLE;
            entry          <= '0;
            digits_entered <= '0;
            fail_count     <= '0;
`ifdef COMBO_LOCK_PROG_EN
            combo          <= COMBO;
            shadow         <= '0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE, ST_ENTER: begin
                    if (clear) begin
                        entry          <= '0;
                        digits_entered <= '0;
                    end else if (digit_valid) begin
                        entry          <= (entry << DIGIT_W) | EW'(digit);
                        digits_entered <= digits_entered + 1'b1;
                    end
                end
                ST_CHECK: begin
                    digits_entered <= '0;
                    if (match) begin
                        fail_count <= '0;
                    end
                end
                ST_FAIL: begin
                    fail_count <= fail_inc;
                end
                ST_LOCKOUT: begin
                    if (tmr_done) begin
                        fail_count <= '0;
                    end
                end
`ifdef COMBO_LOCK_PROG_EN
                ST_OPEN: begin
                    if (!clear && prog) begin
                        shadow         <= '0;
                        digits_entered <= '0;
                    end
                end
                ST_PROGRAM: begin
                    if (clear) begin
                        digits_entered <= '0;
                    end else if (last_digit) begin
                        combo          <= shadow_nxt;
                        digits_entered <= '0;
                    end else if (digit_valid) begin
                        shadow         <= shadow_nxt;
                        digits_entered <= digits_entered + 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign unlocked  = (state == ST_OPEN) || (state == ST_PROGRAM);
    assign bad_pulse = (state == ST_FAIL);
    assign alarm     = (state == ST_LOCKOUT);

endmodule

// File: tb/tb_combo_lock_fsm.sv
// Bench for combo_lock_fsm: event-level reference model feeds a scoreboard of expected output edges.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_combo_lock_fsm;

    localparam int OPEN_N = 8;
    localparam int LOCK_N = 16;
    localparam int TRIES  = 3;
    localparam int CLEN   = 4;
`ifdef COMBO_LOCK_PROG_EN
    localparam bit PROG_BUILD = 1'b1;
`else
    localparam bit PROG_BUILD = 1'b0;
`endif

    localparam int EV_URISE = 0;
    localparam int EV_UFALL = 1;
    localparam int EV_BAD   = 2;
    localparam int EV_ARISE = 3;
    localparam int EV_AFALL = 4;

    logic       Clock       = 1'b0;
    logic       Resetn      = 1'b0;
    logic       digit_valid = 1'b0;
    logic       clear       = 1'b0;
    logic [3:0] digit       = 4'd0;
`ifdef COMBO_LOCK_PROG_EN
    logic       prog        = 1'b0;
`endif
    logic       unlocked;
    logic       bad_pulse;
    logic       alarm;
    logic [2:0] digits_entered;
    logic [1:0] fail_count;

    combo_lock_fsm #(
        .CODE_LEN       (CLEN),
        .DIGIT_W        (4),
        .COMBO          (16'h1234),
        .MAX_TRIES      (TRIES),
        .OPEN_CYCLES    (OPEN_N),
        .LOCKOUT_CYCLES (LOCK_N)
    ) dut (
        .Clock          (Clock),
        .Resetn         (Resetn),
        .digit_valid    (digit_valid),
        .digit          (digit),
        .clear          (clear),
`ifdef COMBO_LOCK_PROG_EN
        .prog           (prog),
`endif
        .unlocked       (unlocked),
        .bad_pulse      (bad_pulse),
        .alarm          (alarm),
        .digits_entered (digits_entered),
        .fail_count     (fail_count)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  tests   = 0;
    int  fails_n = 0;

    // reference model state: kept as digit lists and time windows
    logic [3:0] mq[$];
    logic [3:0] pq[$];
    logic [3:0] mcombo[CLEN];
    int  mfails     = 0;
    int  busy_until = 0;
    int  open_s     = -1;
    int  open_e     = -2;
    int  check_cyc  = -1;
    bit  prog_mode  = 1'b0;

    task automatic chk(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails_n++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic expect_ev(input int k, input int c);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic retime_last(input int c);
        ev_t e;
        e = exp_q.pop_back();
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int k);
        ev_t e;
        if (exp_q.size() == 0) begin
            tests++;
            fails_n++;
            $display("FAIL unexpected event: got kind %0d at cycle %0d want none", k, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event kind", k, e.kind);
            chk("event cycle", cyc, e.cyc);
        end
    endtask

    // monitor: every edge on unlocked/alarm and every bad_pulse cycle must match the next expected event
    bit   mon_en = 1'b0;
    logic prev_u = 1'b0;
    logic prev_a = 1'b0;
    always @(negedge Clock) begin
        if (mon_en) begin
            if (unlocked !== prev_u) observe(unlocked ? EV_URISE : EV_UFALL);
            if (alarm !== prev_a)    observe(alarm ? EV_ARISE : EV_AFALL);
            if (bad_pulse === 1'b1)  observe(EV_BAD);
            prev_u = unlocked;
            prev_a = alarm;
        end
    end

    task automatic model_reset_combo();
        mcombo[0] = 4'd1;
        mcombo[1] = 4'd2;
        mcombo[2] = 4'd3;
        mcombo[3] = 4'd4;
    endtask

    // inputs applied in cycle n are sampled at the end of n; model predicts outputs in absolute cycles
    task automatic model_step(input int n, input bit dv, input logic [3:0] d,
                              input bit clr, input bit rst, input bit pg);
        bit ok;
        if (rst) begin
            if (prog_mode || (n >= open_s && n <= open_e)) retime_last(n + 1);
            mq.delete();
            pq.delete();
            mfails     = 0;
            prog_mode  = 1'b0;
            busy_until = n + 1;
            open_e     = -2;
            model_reset_combo();
        end else if (prog_mode) begin
            if (clr) begin
                expect_ev(EV_UFALL, n + 1);
                prog_mode  = 1'b0;
                busy_until = n + 1;
            end else if (dv) begin
                pq.push_back(d);
                if (pq.size() == CLEN) begin
                    for (int i = 0; i < CLEN; i++) mcombo[i] = pq[i];
                    pq.delete();
                    expect_ev(EV_UFALL, n + 1);
                    prog_mode  = 1'b0;
                    busy_until = n + 1;
                end
            end
        end else if (n >= open_s && n <= open_e) begin
            if (clr) begin
                retime_last(n + 1);
                busy_until = n + 1;
                open_e     = n;
            end else if (pg && PROG_BUILD) begin
                void'(exp_q.pop_back());
                prog_mode  = 1'b1;
                pq.delete();
                busy_until = 1 << 30;
                open_e     = n;
            end
        end else if (n >= busy_until) begin
            if (clr) begin
                mq.delete();
            end else if (dv) begin
                mq.push_back(d);
                if (mq.size() == CLEN) begin
                    ok = 1'b1;
                    for (int i = 0; i < CLEN; i++) if (mq[i] !== mcombo[i]) ok = 1'b0;
                    mq.delete();
                    check_cyc = n + 1;
                    if (ok) begin
                        mfails     = 0;
                        open_s     = n + 2;
                        open_e     = n + 1 + OPEN_N;
                        busy_until = n + 2 + OPEN_N;
                        expect_ev(EV_URISE, n + 2);
                        expect_ev(EV_UFALL, n + 2 + OPEN_N);
                    end else begin
                        mfails++;
                        expect_ev(EV_BAD, n + 2);
                        if (mfails == TRIES) begin
                            expect_ev(EV_ARISE, n + 3);
                            expect_ev(EV_AFALL, n + 3 + LOCK_N);
                            busy_until = n + 3 + LOCK_N;
                            mfails     = 0;
                        end else begin
                            busy_until = n + 3;
                        end
                    end
                end
            end
        end
    endtask

    task automatic drive(input bit dv, input logic [3:0] d, input bit clr, input bit rst, input bit pg);
        int n;
        @(posedge Clock);
        #1;
        n = cyc;
        if (n == check_cyc) chk("digits_entered in CHECK", int'(digits_entered), CLEN);
        if (n >= busy_until && !prog_mode) begin
            chk("digits_entered", int'(digits_entered), mq.size());
            chk("fail_count", int'(fail_count), mfails);
        end
        digit_valid = dv;
        digit       = d;
        clear       = clr;
        Resetn      = !rst;
`ifdef COMBO_LOCK_PROG_EN
        prog        = pg;
`endif
        model_step(n, dv, d, clr, rst, pg);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic enter(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] e);
        drive(1'b1, a, 1'b0, 1'b0, 1'b0);
        drive(1'b1, b, 1'b0, 1'b0, 1'b0);
        drive(1'b1, c, 1'b0, 1'b0, 1'b0);
        drive(1'b1, e, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset_combo();
        repeat (3) @(posedge Clock);
        #1;
        chk("reset unlocked", int'(unlocked), 0);
        chk("reset bad_pulse", int'(bad_pulse), 0);
        chk("reset alarm", int'(alarm), 0);
        chk("reset digits_entered", int'(digits_entered), 0);
        chk("reset fail_count", int'(fail_count), 0);
        mon_en = 1'b1;

        // correct entry, then a wrong one
        enter(4'd1, 4'd2, 4'd3, 4'd4);
        idle(12);
        enter(4'd1, 4'd2, 4'd3, 4'd5);
        idle(5);

        // two more failures reach lockout; digits hammered during lockout must be ignored
        enter(4'd9, 4'd9, 4'd9, 4'd9);
        idle(4);
        enter(4'd1, 4'd2, 4'd4, 4'd3);
        for (int i = 0; i < 14; i++) drive(1'b1, 4'((i % 4) + 1), 1'b0, 1'b0, 1'b0);
        idle(8);
        enter(4'd1, 4'd2, 4'd3, 4'd4);
        idle(12);

        // abort: clear wins over a simultaneous digit
        drive(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
        enter(4'd1, 4'd2, 4'd3, 4'd4);
        idle(12);

        // reset during the third cycle of unlocked
        enter(4'd1, 4'd2, 4'd3, 4'd4);
        idle(3);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        idle(5);

`ifdef COMBO_LOCK_PROG_EN
        // reprogram to 9876 with long gaps (open timer must be frozen), then use the new code
        enter(4'd1, 4'd2, 4'd3, 4'd4);
        idle(1);
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            idle(10);
            drive(1'b1, 4'(9 - i), 1'b0, 1'b0, 1'b0);
        end
        idle(3);
        enter(4'd9, 4'd8, 4'd7, 4'd6);
        idle(12);
        enter(4'd1, 4'd2, 4'd3, 4'd4);
        idle(5);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        idle(3);
`endif

        // randomized traffic biased towards the current code
        for (int i = 0; i < 700; i++) begin
            bit         dv;
            bit         clr;
            bit         pg;
            logic [3:0] d;
            dv  = ($urandom_range(0, 1) == 1);
            clr = ($urandom_range(0, 24) == 0);
            pg  = PROG_BUILD && ($urandom_range(0, 39) == 0);
            if (mq.size() < CLEN && $urandom_range(0, 3) != 0) d = mcombo[mq.size()];
            else d = 4'($urandom_range(0, 15));
            drive(dv, d, clr, 1'b0, pg);
        end
        idle(30);
        chk("event queue drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails_n);
        $finish;
    end

endmodule
